kulisch_to_fp16: RTL

Converts one Kulisch accumulator word, produced by the tensor-core MMA datapath, back into an IEEE-754 binary16 value. Rounding is round-to-nearest-even, and the overflow, underflow and inexact flags are reported with the result. The block sits at the write-back end of the tensor core, between the accumulator register file and the fp16 result bus. It is a non-pipelined, multi-cycle converter with a fixed 8-cycle latency and valid/ready handshakes on both sides.

---
 rtl/tensor_core_pkg.sv | 22 ++
 rtl/fp16_rne_pack.sv | 41 ++++
 rtl/kulisch_to_fp16.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// Shared tensor-core formats: Kulisch accumulator geometry, fp16
// encoding constants and the accumulator-to-fp16 converter states.
package tensor_core_pkg;

    localparam int AWIDTH = 91;
    localparam int FRAC   = 48;
    localparam int EWIDTH = 5;
    localparam int MWIDTH = 10;
    localparam int BIAS   = 15;
    localparam int SMAX   = (AWIDTH - 1) - (FRAC - (BIAS - 1));

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_INF  = 16'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp16_rne_pack.sv
// Round-to-nearest-even and pack of a pre-normalised fp16 candidate,
// including saturation to infinity and the IEEE status flags.
module fp16_rne_pack
    import tensor_core_pkg::*;
(
    input  logic              sign,
    input  logic [EWIDTH:0]   exp,
    input  logic [MWIDTH-1:0] mant,
    input  logic              guard,
    input  logic              sticky,
    output logic [15:0]       fp,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    localparam logic [EWIDTH:0] EXP_SAT = {1'b0, {EWIDTH{1'b1}}};

    logic                     rnd;
    logic [EWIDTH+MWIDTH-1:0] sum;

    always_comb begin
        rnd       = guard & (sticky | mant[0]);
        // Carry out of the mantissa bumps the exponent; 31/0 is Inf.
        sum       = {exp[EWIDTH-1:0], mant}
                  + {{(EWIDTH+MWIDTH-1){1'b0}}, rnd};
        inexact   = guard | sticky;
        overflow  = 1'b0;
        underflow = 1'b0;
        fp        = {sign, sum};
        if (exp >= EXP_SAT) begin
            fp       = FP16_INF | {sign, 15'b0};
            overflow = 1'b1;
            inexact  = 1'b1;
        end else begin
            overflow  = &sum[EWIDTH+MWIDTH-1:MWIDTH];
            underflow = (exp == '0) & inexact;
        end
    end

endmodule

// File: rtl/kulisch_to_fp16.sv
// Multi-cycle Kulisch accumulator to fp16 converter: sign-magnitude
// load, 7-step binary leading-zero normaliser, then RNE pack.
module kulisch_to_fp16 #(
    parameter int AWIDTH = 91,
    parameter int FRAC   = 48,
    parameter int DWIDTH = 16,
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10,
    parameter int BIAS   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_acc,
    input  logic              in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_fp,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);

    import tensor_core_pkg::state_t;
    import tensor_core_pkg::IDLE;
    import tensor_core_pkg::NORM;
    import tensor_core_pkg::ROUND;
    import tensor_core_pkg::DONE;
    import tensor_core_pkg::FP16_QNAN;

    localparam int SMAX_L = (AWIDTH - 1) - (FRAC - (BIAS - 1));

    state_t state, state_nxt;

    logic [AWIDTH-1:0] mag;
    logic [6:0]        s;
    logic [2:0]        step;
    logic              sign;
    logic              exc;

    logic [6:0]        k;
    logic              top_zero;
    logic              fits;
    logic [EWIDTH:0]   exp_pre;

    logic [15:0]       pk_fp;
    logic              pk_ov;
    logic              pk_uf;
    logic              pk_ix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        k        = 7'd64 >> step;
        top_zero = (mag >> (7'(AWIDTH) - k)) == '0;
        fits     = (8'(s) + 8'(k)) <= 8'(SMAX_L);
        exp_pre  = '0;
        if (mag[AWIDTH-1])
            exp_pre = (EWIDTH+1)'(SMAX_L + 1) - (EWIDTH+1)'(s);
    end

    fp16_rne_pack u_pack (
        .sign      (sign),
        .exp       (exp_pre),
        .mant      (mag[AWIDTH-2 -: MWIDTH]),
        .guard     (mag[AWIDTH-2-MWIDTH]),
        .sticky    (|mag[AWIDTH-3-MWIDTH:0]),
        .fp        (pk_fp),
        .overflow  (pk_ov),
        .underflow (pk_uf),
        .inexact   (pk_ix)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (in_valid) state_nxt = NORM;
            NORM:  if (step == 3'd6) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag           <= '0;
            s             <= '0;
            step          <= '0;
            sign          <= 1'b0;
            exc           <= 1'b0;
            out_fp        <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_acc[AWIDTH-1];
                        mag  <= in_acc[AWIDTH-1] ? '0 - in_acc : in_acc;
                        s    <= '0;
                        step <= '0;
                        exc  <= in_exc;
                    end
                end
                NORM: begin
                    // Greedy shift stops at SMAX so tiny values land subnormal.
                    if (top_zero && fits) begin
                        mag <= mag << k;
                        s   <= s + k;
                    end
                    step <= step + 3'd1;
                end
                ROUND: begin
                    if (exc) begin
                        out_fp        <= DWIDTH'(FP16_QNAN);
                        out_overflow  <= 1'b0;
                        out_underflow <= 1'b0;
                        out_inexact   <= 1'b0;
                    end else if (mag == '0) begin
                        out_fp        <= '0;
                        out_overflow  <= 1'b0;
                        out_underflow <= 1'b0;
                        out_inexact   <= 1'b0;
                    end else begin
                        out_fp        <= DWIDTH'(pk_fp);
                        out_overflow  <= pk_ov;
                        out_underflow <= pk_uf;
                        out_inexact   <= pk_ix;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
